// File: rtl/wb_queue.sv
// Writeback queue: merges load and ALU results into one register-file write port.
// Entries drain one per cycle in FIFO order; a lookup port exposes pending writes.
module wb_queue #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [ASIZE-1:0] mem_addr,
  input  logic [DSIZE-1:0] mem_data,
  input  logic             alu_valid,
  input  logic [ASIZE-1:0] alu_addr,
  input  logic [DSIZE-1:0] alu_data,
  output logic             wb_ready,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] lk_addr,
  output logic             lk_hit,
  output logic [DSIZE-1:0] lk_data,
  output logic [ASIZE:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ASIZE-1:0] addr_q [DEPTH];
  logic [DSIZE-1:0] data_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, alu_slot, lk_idx;
  logic [ASIZE:0]   count_q, count_d;
  logic             mem_push, alu_push, pop;

  // Room for two entries is required so both producers can always push together.
  assign wb_ready = (count_q <= (ASIZE+1)'(DEPTH - 2));
  assign mem_push = mem_valid && wb_ready && (mem_addr != '0);
  assign alu_push = alu_valid && wb_ready && (alu_addr != '0);
  assign pop      = (count_q != '0);

  always_comb begin
    head_d   = head_q + PW'(pop);
    alu_slot = tail_q + PW'(mem_push);
    tail_d   = alu_slot + PW'(alu_push);
    count_d  = count_q + (ASIZE+1)'(mem_push) + (ASIZE+1)'(alu_push) - (ASIZE+1)'(pop);
  end

  // Storage is not cleared on reset; count_q masks stale entries from every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (mem_push) begin
        addr_q[tail_q] <= mem_addr;
        data_q[tail_q] <= mem_data;
      end
      if (alu_push) begin
        addr_q[alu_slot] <= alu_addr;
        data_q[alu_slot] <= alu_data;
      end
    end
  end

  assign wen   = pop;
  assign waddr = pop ? addr_q[head_q] : '0;
  assign wdata = pop ? data_q[head_q] : '0;
  assign count = count_q;

  // Walk oldest to newest so the entry closest to tail wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if (((ASIZE+1)'(i) < count_q) && (addr_q[lk_idx] == lk_addr) && (lk_addr != '0)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios then random traffic, checked against a queue model.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic [3:0]  mem_addr, alu_addr, lk_addr, waddr;
  logic [15:0] mem_data, alu_data, wdata, lk_data;
  logic        wb_ready, wen, lk_hit;
  logic [4:0]  count;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;
  ent_t mq[$];

  wb_queue #(.DSIZE(16), .ASIZE(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .wb_ready(wb_ready), .wen(wen), .waddr(waddr), .wdata(wdata),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, clock, advance the model.
  task automatic cyc(input logic r,
                     input logic mv, input logic [3:0] ma, input logic [15:0] md,
                     input logic av, input logic [3:0] aa, input logic [15:0] ad,
                     input logic [3:0] lk);
    logic        e_hit;
    logic [15:0] e_lkd;
    logic        ready;
    rst = r; mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad; lk_addr = lk;
    #1;
    e_hit = 1'b0; e_lkd = 16'h0;
    if (lk != 4'd0)
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].a == lk) begin e_hit = 1'b1; e_lkd = mq[i].d; end
    chk("wen",      wen,      mq.size() > 0);
    chk("waddr",    waddr,    mq.size() > 0 ? mq[0].a : 4'd0);
    chk("wdata",    wdata,    mq.size() > 0 ? mq[0].d : 16'd0);
    chk("count",    count,    mq.size());
    chk("wb_ready", wb_ready, (4 - mq.size()) >= 2);
    chk("lk_hit",   lk_hit,   e_hit);
    chk("lk_data",  lk_data,  e_lkd);
    @(posedge clk);
    ready = (4 - mq.size()) >= 2;
    if (r) mq.delete();
    else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (mv && ready && ma != 4'd0) mq.push_back('{ma, md});
      if (av && ready && aa != 4'd0) mq.push_back('{aa, ad});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd0);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0;
    mem_addr = '0; alu_addr = '0; mem_data = '0; alu_data = '0; lk_addr = '0;
    @(posedge clk); #1;
    // Reset with requests presented: they must be dropped.
    cyc(1'b1, 1'b1, 4'd3, 16'h1234, 1'b1, 4'd6, 16'h5678, 4'd0);
    idle(1);

    // Single push
    cyc(1'b0, 1'b1, 4'd5, 16'h00AA, 1'b0, 4'd0, 16'd0, 4'd5);
    chk("single_waddr", waddr, 4'd5);
    chk("single_wdata", wdata, 16'h00AA);
    idle(3);

    // Dual push: mem first, then alu
    cyc(1'b0, 1'b1, 4'd3, 16'h1111, 1'b1, 4'd7, 16'h2222, 4'd0);
    chk("dual_first", waddr, 4'd3);
    idle(3);

    // Fill and backpressure with held requests
    cyc(1'b0, 1'b1, 4'd1, 16'h000A, 1'b1, 4'd2, 16'h000B, 4'd1);
    cyc(1'b0, 1'b1, 4'd3, 16'h000C, 1'b1, 4'd4, 16'h000D, 4'd2);
    chk("fill_ready_low", wb_ready, 1'b0);
    cyc(1'b0, 1'b1, 4'd5, 16'h000E, 1'b1, 4'd6, 16'h000F, 4'd3);
    cyc(1'b0, 1'b1, 4'd5, 16'h000E, 1'b1, 4'd6, 16'h000F, 4'd4);
    idle(5);

    // Address zero discarded
    cyc(1'b0, 1'b1, 4'd2, 16'h0042, 1'b1, 4'd0, 16'hFFFF, 4'd0);
    chk("zero_count", count, 5'd1);
    idle(2);

    // Lookup: newest match wins
    cyc(1'b0, 1'b1, 4'd4, 16'h0010, 1'b1, 4'd4, 16'h0020, 4'd0);
    lk_addr = 4'd4; #1;
    chk("lk4_hit", lk_hit, 1'b1);
    chk("lk4_data", lk_data, 16'h0020);
    cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd9);
    cyc(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd0);
    idle(1);

    // Reset mid-operation at count=3
    cyc(1'b0, 1'b1, 4'd8, 16'h0808, 1'b1, 4'd9, 16'h0909, 4'd0);
    cyc(1'b0, 1'b1, 4'd10, 16'h0A0A, 1'b1, 4'd11, 16'h0B0B, 4'd0);
    chk("mid_count3", count, 5'd3);
    cyc(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 4'd9);
    chk("mid_wen0", wen, 1'b0);
    idle(3);

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 16'($urandom),
          $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), 16'($urandom),
          4'($urandom_range(0, 15)));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter DSIZE, default 16, meaning the register data width.
REQ-002 The block SHALL have parameter ASIZE, default 4, meaning the register address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the queue entries (power of 2, >=2).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning the synchronous active-high reset, sampled on posedge clk.
REQ-006 The block SHALL have port mem_valid, input, 1, meaning a load-result writeback request.
REQ-007 The block SHALL have port mem_addr, input, ASIZE, meaning the load destination register.
REQ-008 The block SHALL have port mem_data, input, DSIZE, meaning the load result.
REQ-009 The block SHALL have port alu_valid, input, 1, meaning an ALU-result writeback request.
REQ-010 The block SHALL have port alu_addr, input, ASIZE, meaning the ALU destination register.
REQ-011 The block SHALL have port alu_data, input, DSIZE, meaning the ALU result.
REQ-012 The block SHALL have port wb_ready, output, 1, meaning both producers may push this cycle.
REQ-013 The block SHALL have port wen, output, 1, meaning the register-file write enable.
REQ-014 The block SHALL have port waddr, output, ASIZE, meaning the register-file write address.
REQ-015 The block SHALL have port wdata, output, DSIZE, meaning the register-file write data.
REQ-016 The block SHALL have port lk_addr, input, ASIZE, meaning the pending-write lookup address.
REQ-017 The block SHALL have port lk_hit, output, 1, meaning a queued entry targets lk_addr.
REQ-018 The block SHALL have port lk_data, output, DSIZE, meaning the data of the newest matching queued entry.
REQ-019 The block SHALL have port count, output, ASIZE+1, meaning the number of occupied entries.

Function
REQ-020 The block SHALL be a circular FIFO of DEPTH {addr,data} entries, with head/tail pointers wrapping modulo DEPTH.
REQ-021 wb_ready SHALL be 1 iff DEPTH-count >= 2, and SHALL be combinational from count only.
REQ-022 A request SHALL be accepted iff its valid input is 1 and wb_ready is 1 in the same cycle; requests with wb_ready=0 SHALL be ignored, and producers hold them.
REQ-023 An accepted request with address 0 SHALL be discarded: not enqueued, count unaffected.
REQ-024 When both requests are accepted and nonzero in one cycle, the mem entry SHALL be enqueued at tail and the alu entry at tail+1.
REQ-025 wen SHALL be 1 iff count>0; waddr/wdata SHALL equal the head entry; while count=0, waddr/wdata SHALL be 0.
REQ-026 The head entry SHALL be popped on every clock with count>0; each entry SHALL be presented for exactly one cycle.
REQ-027 A request accepted in cycle N into an empty queue SHALL appear on wen/waddr/wdata in cycle N+1 (latency 1).
REQ-028 The count update SHALL be count_next = count + pushes(0..2) - pop(0..1), with push and pop in the same cycle permitted.
REQ-029 count SHALL never exceed DEPTH, and no entry SHALL be overwritten before being popped.
REQ-030 lk_hit/lk_data SHALL be combinational over the occupied entries, head included; the newest (closest to tail) match SHALL win.
REQ-031 Requests presented in the same cycle SHALL NOT be visible to lookup.
REQ-032 lk_data SHALL be 0 when lk_hit=0, and a lookup of address 0 SHALL always return lk_hit=0.
REQ-033 Entries SHALL leave in FIFO order; no coalescing of same-address entries SHALL occur.

Reset
REQ-034 While rst=1 at posedge clk, the block SHALL clear head, tail and count to 0 and discard all entries.
REQ-035 In the cycle after reset, outputs SHALL be wen=0, waddr=0, wdata=0, count=0, wb_ready=1, lk_hit=0, lk_data=0.
REQ-036 Requests presented in a reset cycle SHALL be dropped.
REQ-037 Reset asserted mid-operation SHALL discard all pending writes with no partial write after deassertion.

Verification
REQ-038 Single push: reset, mem_valid=1 addr=5 data=16'h00AA for one cycle -> next cycle wen=1, waddr=5, wdata=00AA; cycle after that wen=0, count=0.
REQ-039 Dual push: mem(3,1111) + alu(7,2222) in the same cycle -> wen for two consecutive cycles: (3,1111) then (7,2222).
REQ-040 Fill/backpressure (DEPTH=4): dual pushes for two cycles with pops -> wb_ready drops when count>2; a valid held during wb_ready=0 is not enqueued; no entry is lost; output order is preserved.
REQ-041 Address zero: alu(0,FFFF) + mem(2,0042) -> only (2,0042) is written; count peaks at 1.
REQ-042 Lookup: queue holds (4,0010) then (4,0020), lk_addr=4 -> lk_hit=1, lk_data=0020; lk_addr=9 -> lk_hit=0, lk_data=0.
REQ-043 Reset mid-operation: count=3, rst=1 for one cycle -> next cycle count=0, wen=0, wb_ready=1, and no stale writes thereafter.
